req_ack_arbiter: RTL
====================

REQ_ACK_ARBITER -- requirements
Module: req_ack_arbiter

Interface
REQ-001 Parameter data_width, default 32, width of every data word.
REQ-002 Parameter num_src, default 4, number of upstream sources (2..16).
REQ-003 Parameter timeout, default 64, max cycles a granted source may take to ack (1..65535).
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous and active-low.
REQ-006 Port src_req  out  num_src  per-source request level, at most one bit high.
REQ-007 Port src_ack  in  num_src  per-source one-cycle ack pulse; data valid with it.
REQ-008 Port src_din  in  data_width*num_src  packed source data, slice g = source g.
REQ-009 Port src_en  in  num_src  grant-eligibility mask; sampled only in IDLE.
REQ-010 Port dout_req  in  1  level request from the shared operator input (req_l side).
REQ-011 Port dout_ack  out  1  one-cycle ack pulse to the operator.
REQ-012 Port dout  out  data_width  delivered word, held stable from the ack cycle until the next ack.
REQ-013 Port dout_src  out  clog2(num_src)  index of the source that supplied dout.
REQ-014 Port timeout_err  out  1  one-cycle pulse when a granted source times out.

Function
REQ-015 Block SHALL share one async_operator input among num_src producers using the req/ack pull protocol.
REQ-016 FSM states SHALL be IDLE, FETCH, DELIVER.
REQ-017 IDLE: if dout_req=1, dout_ack=0 and src_en!=0, pick grant g = first enabled index after last_grant (round-robin, wraps num_src-1 -> 0), set src_req[g]=1 next cycle, go FETCH.
REQ-018 IDLE with dout_req=0 or src_en=0 SHALL stay IDLE with src_req all zero.
REQ-019 FETCH: src_req[g] held high; on src_ack[g]=1 capture slice g into holding register, drop src_req[g] next cycle, set last_grant=g, go DELIVER.
REQ-020 FETCH: src_ack on any bit other than g SHALL be ignored (no capture, no state change).
REQ-021 FETCH: wait counter increments each cycle; when it reaches timeout without src_ack[g], drop src_req[g], pulse timeout_err, set last_grant=g, return to IDLE.
REQ-022 src_ack[g] arriving in the same cycle the counter reaches timeout SHALL be honoured as an ack (no timeout_err).
REQ-023 DELIVER: assert dout_ack for exactly one cycle with dout=captured word and dout_src=g, then go IDLE.
REQ-024 Minimum latency dout_req rise -> dout_ack SHALL be 3 cycles when the source acks in the first cycle src_req is seen high.
REQ-025 dout_ack SHALL never be high on two consecutive cycles; back-to-back transfers spaced at least 3 cycles.
REQ-026 src_en changes during FETCH/DELIVER SHALL not abort the current transaction.
REQ-027 dout_req dropping during FETCH SHALL not abort; the captured word is delivered when DELIVER is reached.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, src_req=0, dout_ack=0, dout=0, dout_src=0, timeout_err=0, wait counter=0, last_grant=num_src-1 (first grant = source 0).
REQ-029 Reset asserted mid-FETCH SHALL drop src_req asynchronously; a src_ack arriving during or after reset in IDLE SHALL be discarded.

Structure
REQ-030 Shared package arb_pkg SHALL hold the FSM state encoding (IDLE=0, FETCH=1, DELIVER=2) and the default parameter constants.
REQ-031 Round-robin selection SHALL be a separate combinational sub-module rr_pick (inputs mask, last; outputs grant index, any).
REQ-032 Datapath SHALL be one holding register plus output register; no FIFO.

Verification
REQ-033 Reset, src_en=4'b1111, dout_req held 1, all sources ack in 1 cycle with data 10,20,30,40 -> dout sequence 10,20,30,40,10 with dout_src 0,1,2,3,0.
REQ-034 src_en=4'b0101 -> grants alternate 0,2,0,2; src_req[1] and src_req[3] never high.
REQ-035 timeout=8, source 1 never acks, src_en=4'b0011 -> src_req[1] high exactly 8 cycles, timeout_err one pulse, next grant source 0, no dout_ack for source 1.
REQ-036 During FETCH on source 2, stray src_ack[0] with data 99 -> ignored; dout equals source 2 data.
REQ-037 rst low for 1 cycle mid-FETCH -> src_req all zero within the reset cycle; after release first grant is source 0.
REQ-038 Throughput check: 4 sources always ready, 1000 transfers -> dout_ack never consecutive, each source served 250 times.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the request/acknowledge arbiter:
// FSM state encoding and default parameter values.
package arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_FETCH   = 2'd1;
  localparam state_t ST_DELIVER = 2'd2;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_TIMEOUT    = 64;

  // Wide enough for the largest permitted timeout (65535).
  localparam int CNT_W = 16;

endpackage

// File: rtl/req_ack_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first enabled index
// strictly after 'last', wrapping from NUM-1 back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int NUM = DEF_NUM_SRC,
  localparam int IW  = $clog2(NUM)
) (
  input  logic [NUM-1:0] mask,
  input  logic [IW-1:0]  last,
  output logic [IW-1:0]  grant,
  output logic           any
);

  int w_idx;

  // Scan from the farthest offset down so the nearest enabled index wins.
  always_comb begin
    grant = '0;
    w_idx = 0;
    for (int k = NUM; k >= 1; k--) begin
      w_idx = int'(last) + k;
      if (w_idx >= NUM) w_idx = w_idx - NUM;
      if (mask[w_idx[IW-1:0]]) grant = w_idx[IW-1:0];
    end
  end

  assign any = |mask;

endmodule

// File: rtl/req_ack_arbiter.sv
// Shares one req/ack pull-protocol operator input among num_src producers,
// serving them round-robin with a per-grant acknowledge timeout.
module req_ack_arbiter
  import arb_pkg::*;
#(
  parameter  int data_width = DEF_DATA_WIDTH,
  parameter  int num_src    = DEF_NUM_SRC,
  parameter  int timeout    = DEF_TIMEOUT,
  localparam int IW         = $clog2(num_src)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [num_src-1:0]             src_req,
  input  logic [num_src-1:0]             src_ack,
  input  logic [data_width*num_src-1:0]  src_din,
  input  logic [num_src-1:0]             src_en,
  input  logic                           dout_req,
  output logic                           dout_ack,
  output logic [data_width-1:0]          dout,
  output logic [IW-1:0]                  dout_src,
  output logic                           timeout_err
);

  localparam logic [num_src-1:0] ONE     = num_src'(1);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(timeout - 1);

  state_t                  r_state;
  logic [num_src-1:0]      r_src_req;
  logic [IW-1:0]           r_grant;
  logic [IW-1:0]           r_last;
  logic [CNT_W-1:0]        r_cnt;
  logic [data_width-1:0]   r_hold;
  logic [data_width-1:0]   r_dout;
  logic [IW-1:0]           r_dout_src;
  logic                    r_dout_ack;
  logic                    r_timeout_err;

  logic [IW-1:0]           w_pick;
  logic                    w_any;
  logic                    w_ack_g;
  logic [data_width-1:0]   w_din [num_src];

  for (genvar g = 0; g < num_src; g++) begin : g_slice
    assign w_din[g] = src_din[g*data_width +: data_width];
  end

  assign w_ack_g = src_ack[r_grant];

  rr_pick #(.NUM(num_src)) u_rr_pick (
    .mask  (src_en),
    .last  (r_last),
    .grant (w_pick),
    .any   (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_src_req     <= '0;
      r_grant       <= '0;
      r_last        <= IW'(num_src - 1);
      r_cnt         <= '0;
      r_dout        <= '0;
      r_dout_src    <= '0;
      r_dout_ack    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dout_ack    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The ack cycle itself blocks a new grant, guaranteeing a gap.
          if (dout_req && !r_dout_ack && w_any) begin
            r_grant   <= w_pick;
            r_src_req <= ONE << w_pick;
            r_cnt     <= '0;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // An ack landing on the final counted cycle still wins over the timeout.
          if (w_ack_g) begin
            r_src_req <= '0;
            r_last    <= r_grant;
            r_state   <= ST_DELIVER;
          end else if (r_cnt == TO_LAST) begin
            r_src_req     <= '0;
            r_timeout_err <= 1'b1;
            r_last        <= r_grant;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DELIVER: begin
          r_dout_ack <= 1'b1;
          r_dout     <= r_hold;
          r_dout_src <= r_grant;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Holding register is pure data; only the granted source's ack loads it.
  always_ff @(posedge clk) begin
    if (r_state == ST_FETCH && w_ack_g) r_hold <= w_din[r_grant];
  end

  assign src_req     = r_src_req;
  assign dout_ack    = r_dout_ack;
  assign dout        = r_dout;
  assign dout_src    = r_dout_src;
  assign timeout_err = r_timeout_err;

endmodule
